mole_scheduler: RTL and testbench
=================================

# mole_scheduler

Game-round controller that sits directly downstream of the 3-bit mole-position LFSR. It samples the free-running LFSR state at the end of each inter-mole gap and maps it non-uniformly to one of four boxes. It shows the mole in that box for a bounded window and judges player hits. It also keeps score and miss counts and ends the game after a configured number of misses.

## Interface
- VISIBLE_CYCLES, 25_000_000: cycles a mole stays up if not hit (≥2).
- GAP_CYCLES, 12_500_000: cycles with no mole between moles (≥2).
- MAX_MISSES, 3: misses that end the game (1..15).
- SCORE_W, 8: score width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin or restart a game; sampled only in IDLE and OVER.
- lfsr_in  in  3  current LFSR state, free-running upstream.
- hit_in  in  4  per-box hit strobes, already synchronized and single-cycle.
- mole_valid  out  1  a mole is currently shown.
- mole_onehot  out  4  one-hot box of the shown mole; 0 when none.
- box_idx  out  2  index of the current or last mole.
- score  out  SCORE_W  successful hits, saturating.
- misses  out  4  moles that timed out.
- hit_pulse  out  1  one-cycle strobe on a scored hit.
- miss_pulse  out  1  one-cycle strobe on a timeout.
- game_over  out  1  high while in OVER.

## Operation
- States: IDLE, GAP, SHOW, OVER. All outputs are registered.
- Reset applies on the next edge from any state: state=IDLE, all outputs 0, timer 0.
- IDLE: when start=1, clear score and misses, load timer with GAP_CYCLES-1, and go to GAP.
- GAP:
  - Timer decrements each cycle.
  - At timer==0, sample lfsr_in and map it to box_idx, load timer with VISIBLE_CYCLES-1, and go to SHOW.
- Mapping:
  - 001, 010, 100 → 0
  - 011, 101 → 1
  - 110 → 2
  - 111 → 3
  - 000 (illegal lock-up state) → 0
- SHOW:
  - mole_valid=1 and mole_onehot=1<<box_idx. Timer decrements each cycle.
  - If hit_in[box_idx]=1: score+1 (holds at all-ones), hit_pulse, load GAP_CYCLES-1, go to GAP.
  - Otherwise, at timer==0: miss_pulse and misses+1. If the new misses==MAX_MISSES, go to OVER; else load GAP_CYCLES-1 and go to GAP.
  - hit_in bits for other boxes are ignored, with no penalty. hit_in in IDLE, GAP, and OVER is ignored.
- Simultaneous events in SHOW:
  - A hit on the same cycle as timer==0 counts as a hit, not a miss.
  - Multiple hit_in bits set: only bit box_idx matters.
- OVER:
  - game_over=1, mole outputs 0; score and misses hold.
  - When start=1, behave exactly as IDLE does on start (clear counters, go to GAP); game_over drops on that edge.
- start is ignored in GAP and SHOW.
- box_idx holds its last value outside SHOW.

## Timing
- Timer width is $clog2 of the larger of VISIBLE_CYCLES and GAP_CYCLES.
- With start seen at edge N, GAP is active for edges N+1..N+GAP_CYCLES. mole_valid rises on edge N+GAP_CYCLES.
- An unhit mole stays visible for exactly VISIBLE_CYCLES cycles. miss_pulse and mole_valid=0 appear on the same edge.
- Hit latency: hit_in sampled at edge M gives hit_pulse=1, score updated, and mole_onehot=0 after edge M.
- lfsr_in is sampled once per mole, only on the GAP→SHOW edge.
- hit_pulse and miss_pulse are each high for exactly one cycle and are never high together.

## Test plan
Tests use VISIBLE_CYCLES=8, GAP_CYCLES=4, MAX_MISSES=3, SCORE_W=2.
- Mapping sweep: force lfsr_in to each of 000..111 at the GAP end → box_idx 0,0,0,1,0,1,2,3 respectively, with mole_onehot matching.
- Hit: lfsr_in=110, start, then hit_in=0100 on the 3rd SHOW cycle → hit_pulse for 1 cycle, score=1, mole_onehot=0, next mole after 4 cycles.
- Wrong box then timeout: box 3 shown, hit_in=0001 → no score; after 8 cycles miss_pulse, misses=1.
- Last-cycle hit: hit_in[box] asserted on the final SHOW cycle together with hit_in[other] → score increments, misses unchanged, no miss_pulse.
- Game over and saturation:
  - 5 hits → score saturates at 3.
  - Then 3 timeouts → game_over=1, score=3, misses=3, outputs frozen.
  - start → game_over=0, score=0, misses=0, mole after 4 cycles.
- Reset mid-SHOW: reset=1 for 1 cycle → next edge all outputs 0, state IDLE, no pulses; start is required to resume.

Source files
------------

// File: rtl/mole_if.sv
`default_nettype none
// ============================================================================
//  Module   : mole_if
//  Purpose  : Signal bundle between the mole-game controller and its
//             surroundings (player input, LFSR source, display/score sinks).
//  Ports    :
//    start        begin/restart a game
//    lfsr_in[2:0] free-running mole-position LFSR state
//    hit_in[3:0]  per-box single-cycle hit strobes
//    mole_valid   a mole is currently shown
//    mole_onehot  one-hot box of the shown mole (0 when none)
//    box_idx      index of the current or last mole
//    score        saturating hit count (SCORE_W bits)
//    misses       timed-out mole count
//    hit_pulse    one-cycle strobe on a scored hit
//    miss_pulse   one-cycle strobe on a timeout
//    game_over    high while the game is over
//  Modports : master drives the inputs of the controller, slave is the
//             controller itself.
//  Revision : 1.0  initial release
// ============================================================================
interface mole_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic [2:0]         lfsr_in;
  logic [3:0]         hit_in;
  logic               mole_valid;
  logic [3:0]         mole_onehot;
  logic [1:0]         box_idx;
  logic [SCORE_W-1:0] score;
  logic [3:0]         misses;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               game_over;

  modport master (
    output start, lfsr_in, hit_in,
    input  mole_valid, mole_onehot, box_idx, score, misses,
           hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  start, lfsr_in, hit_in,
    output mole_valid, mole_onehot, box_idx, score, misses,
           hit_pulse, miss_pulse, game_over
  );
endinterface
`default_nettype wire

// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mole_scheduler
//  Purpose  : Whack-a-mole round controller. Waits GAP_CYCLES, samples the
//             upstream LFSR to pick one of four boxes (non-uniform map),
//             shows the mole for up to VISIBLE_CYCLES, judges hits, keeps a
//             saturating score and a miss count, and ends the game after
//             MAX_MISSES timeouts.
//  Ports    :
//    clk    system clock
//    reset  synchronous, active-high reset
//    bus    mole_if.slave: start, lfsr_in, hit_in in; mole_valid,
//           mole_onehot, box_idx, score, misses, hit_pulse, miss_pulse,
//           game_over out (all registered)
//  Revision : 1.0  initial release
// ============================================================================
module mole_scheduler #(
  parameter int VISIBLE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int MAX_MISSES     = 3,
  parameter int SCORE_W        = 8
) (
  input  logic   clk,
  input  logic   reset,
  mole_if.slave  bus
);

  localparam int c_max_cycles = (VISIBLE_CYCLES > GAP_CYCLES) ? VISIBLE_CYCLES : GAP_CYCLES;
  localparam int c_timer_w    = $clog2(c_max_cycles);

  localparam logic [c_timer_w-1:0] c_vis_load = c_timer_w'(VISIBLE_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_gap_load = c_timer_w'(GAP_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);
  localparam logic [SCORE_W-1:0]   c_score_max = '1;
  localparam logic [SCORE_W-1:0]   c_score_one = SCORE_W'(1);
  localparam logic [3:0]           c_max_misses = 4'(MAX_MISSES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  state_t               r_state,  w_state_nxt;
  logic [c_timer_w-1:0] r_timer,  w_timer_nxt;
  logic [1:0]           r_box,    w_box_nxt;
  logic [SCORE_W-1:0]   r_score,  w_score_nxt;
  logic [3:0]           r_misses, w_misses_nxt;
  logic                 r_valid,  w_valid_nxt;
  logic [3:0]           r_onehot, w_onehot_nxt;
  logic                 r_hit,    w_hit_nxt;
  logic                 r_miss,   w_miss_nxt;
  logic                 r_over,   w_over_nxt;

  logic [1:0]           w_box_map;
  logic [3:0]           w_misses_inc;

  // Non-uniform LFSR-to-box map; the all-zero lock-up state lands on box 0.
  always_comb begin
    w_box_map = 2'd0;
    case (bus.lfsr_in)
      3'b011, 3'b101: w_box_map = 2'd1;
      3'b110:         w_box_map = 2'd2;
      3'b111:         w_box_map = 2'd3;
      default:        w_box_map = 2'd0;
    endcase
  end

  assign w_misses_inc = r_misses + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_box    <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_valid  <= 1'b0;
      r_onehot <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_box    <= w_box_nxt;
      r_score  <= w_score_nxt;
      r_misses <= w_misses_nxt;
      r_valid  <= w_valid_nxt;
      r_onehot <= w_onehot_nxt;
      r_hit    <= w_hit_nxt;
      r_miss   <= w_miss_nxt;
      r_over   <= w_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_box_nxt    = r_box;
    w_score_nxt  = r_score;
    w_misses_nxt = r_misses;
    w_valid_nxt  = r_valid;
    w_onehot_nxt = r_onehot;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
    w_over_nxt   = r_over;

    case (r_state)
      // IDLE and OVER share the start behaviour; OVER merely holds the
      // counters and game_over until then.
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          w_score_nxt  = '0;
          w_misses_nxt = '0;
          w_timer_nxt  = c_gap_load;
          w_over_nxt   = 1'b0;
          w_state_nxt  = ST_GAP;
        end
      end

      ST_GAP: begin
        if (r_timer == '0) begin
          // The only point where lfsr_in is observed for this mole.
          w_box_nxt    = w_box_map;
          w_onehot_nxt = 4'b0001 << w_box_map;
          w_valid_nxt  = 1'b1;
          w_timer_nxt  = c_vis_load;
          w_state_nxt  = ST_SHOW;
        end else begin
          w_timer_nxt = r_timer - c_timer_one;
        end
      end

      ST_SHOW: begin
        // Hit is checked first so a hit on the final visible cycle wins
        // over the timeout.
        if (bus.hit_in[r_box]) begin
          w_score_nxt  = (r_score == c_score_max) ? r_score : r_score + c_score_one;
          w_hit_nxt    = 1'b1;
          w_valid_nxt  = 1'b0;
          w_onehot_nxt = '0;
          w_timer_nxt  = c_gap_load;
          w_state_nxt  = ST_GAP;
        end else if (r_timer == '0) begin
          w_miss_nxt   = 1'b1;
          w_misses_nxt = w_misses_inc;
          w_valid_nxt  = 1'b0;
          w_onehot_nxt = '0;
          if (w_misses_inc == c_max_misses) begin
            w_over_nxt  = 1'b1;
            w_state_nxt = ST_OVER;
          end else begin
            w_timer_nxt = c_gap_load;
            w_state_nxt = ST_GAP;
          end
        end else begin
          w_timer_nxt = r_timer - c_timer_one;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mole_valid  = r_valid;
  assign bus.mole_onehot = r_onehot;
  assign bus.box_idx     = r_box;
  assign bus.score       = r_score;
  assign bus.misses      = r_misses;
  assign bus.hit_pulse   = r_hit;
  assign bus.miss_pulse  = r_miss;
  assign bus.game_over   = r_over;

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mole_scheduler
//  Purpose  : Self-checking bench for mole_scheduler. Stimulus pushes the
//             expected output events (mole shown, hit, miss, game over) with
//             their expected cycle into a queue; a monitor pops and compares
//             each event as the DUT presents it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mole_scheduler;
  localparam int V    = 8;
  localparam int G    = 4;
  localparam int MAXM = 3;
  localparam int SW   = 2;
  localparam int SMAX = (1 << SW) - 1;

  localparam int EV_MOLE = 0;
  localparam int EV_HIT  = 1;
  localparam int EV_MISS = 2;
  localparam int EV_OVER = 3;

  typedef struct {
    int kind;
    int cyc;
    int box;
    int score;
    int misses;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  ev_t  expq[$];
  int   map_tab [8] = '{0, 0, 0, 1, 0, 1, 2, 3};
  int   mole_at    = 0;
  int   exp_score  = 0;
  int   exp_misses = 0;
  logic prev_valid = 1'b0;
  logic prev_over  = 1'b0;

  mole_if #(.SCORE_W(SW)) bus ();

  mole_scheduler #(
    .VISIBLE_CYCLES (V),
    .GAP_CYCLES     (G),
    .MAX_MISSES     (MAXM),
    .SCORE_W        (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] oh(input int b);
    oh = 4'b0001 << b;
  endfunction

  task automatic push_ev(input int kind, input int c, input int b, input int s, input int m);
    ev_t e;
    e.kind = kind; e.cyc = c; e.box = b; e.score = s; e.misses = m;
    expq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic take(input int kind);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", kind, cyc);
      return;
    end
    e = expq.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    case (kind)
      EV_MOLE: begin
        chk("mole_box_idx", int'(bus.box_idx), e.box);
        chk("mole_onehot", int'(bus.mole_onehot), int'(oh(e.box)));
      end
      EV_HIT: begin
        chk("hit_score", int'(bus.score), e.score);
        chk("hit_misses", int'(bus.misses), e.misses);
        chk("hit_box_idx", int'(bus.box_idx), e.box);
        chk("hit_mole_onehot", int'(bus.mole_onehot), 0);
        chk("hit_mole_valid", int'(bus.mole_valid), 0);
      end
      EV_MISS: begin
        chk("miss_misses", int'(bus.misses), e.misses);
        chk("miss_score", int'(bus.score), e.score);
        chk("miss_box_idx", int'(bus.box_idx), e.box);
        chk("miss_mole_valid", int'(bus.mole_valid), 0);
      end
      default: begin
        chk("over_score", int'(bus.score), e.score);
        chk("over_misses", int'(bus.misses), e.misses);
        chk("over_mole_valid", int'(bus.mole_valid), 0);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (bus.hit_pulse === 1'b1 && bus.miss_pulse === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL pulse_overlap: got hit=1 miss=1 expected not both at cycle %0d", cyc);
    end
    if (bus.mole_valid === 1'b1 && prev_valid !== 1'b1) take(EV_MOLE);
    if (bus.hit_pulse === 1'b1) take(EV_HIT);
    if (bus.miss_pulse === 1'b1) take(EV_MISS);
    if (bus.game_over === 1'b1 && prev_over !== 1'b1) take(EV_OVER);
    prev_valid = bus.mole_valid;
    prev_over  = bus.game_over;
  end

  // ---------------- stimulus helpers ----------------
  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mole_valid"},  int'(bus.mole_valid), 0);
    chk({tag, "_mole_onehot"}, int'(bus.mole_onehot), 0);
    chk({tag, "_box_idx"},     int'(bus.box_idx), 0);
    chk({tag, "_score"},       int'(bus.score), 0);
    chk({tag, "_misses"},      int'(bus.misses), 0);
    chk({tag, "_hit_pulse"},   int'(bus.hit_pulse), 0);
    chk({tag, "_miss_pulse"},  int'(bus.miss_pulse), 0);
    chk({tag, "_game_over"},   int'(bus.game_over), 0);
  endtask

  task automatic start_game();
    int c;
    c = cyc;
    bus.start = 1'b1;
    goto(c + 1);
    bus.start = 1'b0;
    chk("start_game_over", int'(bus.game_over), 0);
    chk("start_score", int'(bus.score), 0);
    chk("start_misses", int'(bus.misses), 0);
    chk("start_mole_valid", int'(bus.mole_valid), 0);
    exp_score  = 0;
    exp_misses = 0;
    mole_at    = c + 1 + G;
  endtask

  // One mole: lf is presented on the GAP->SHOW edge; hits (if k>0) are
  // presented for the k-th SHOW cycle. start is pulsed in GAP and SHOW to
  // show it is ignored, and lfsr_in changes after sampling.
  task automatic run_mole(input logic [2:0] lf, input int k, input logic [3:0] hits);
    int m, b, c_end;
    m = mole_at;
    b = map_tab[lf];
    goto(m - 2);
    bus.start   = 1'b1;
    bus.lfsr_in = ~lf;
    goto(m - 1);
    bus.start   = 1'b0;
    bus.lfsr_in = lf;
    push_ev(EV_MOLE, m, b, exp_score, exp_misses);
    if (k >= 1 && k <= V && hits[b]) begin
      c_end = m + k;
      exp_score = (exp_score == SMAX) ? SMAX : exp_score + 1;
      push_ev(EV_HIT, c_end, b, exp_score, exp_misses);
    end else begin
      c_end = m + V;
      exp_misses++;
      push_ev(EV_MISS, c_end, b, exp_score, exp_misses);
      if (exp_misses == MAXM) push_ev(EV_OVER, c_end, b, exp_score, exp_misses);
    end
    mole_at = c_end + G;
    goto(m);
    bus.start   = 1'b1;
    bus.lfsr_in = lf ^ 3'b101;
    if (k == 1) bus.hit_in = hits;
    goto(m + 1);
    bus.start  = 1'b0;
    bus.hit_in = 4'b0000;
    if (k >= 2) begin
      goto(m + k - 1);
      bus.hit_in = hits;
      goto(m + k);
      bus.hit_in = 4'b0000;
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int over_cyc, m;
    bus.start   = 1'b0;
    bus.lfsr_in = 3'b001;
    bus.hit_in  = 4'b0000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_all_zero("reset");
    goto(cyc + 2);

    start_game();
    run_mole(3'b110, 3, 4'b0100);                 // hit on 3rd SHOW cycle
    for (int i = 0; i < 8; i++) begin             // mapping sweep, score saturates
      run_mole(3'(i), 1 + 2 * (i % 4), oh(map_tab[i]) | ((i % 2 == 1) ? 4'b1000 : 4'b0000));
    end
    run_mole(3'b111, 2, 4'b0001);                 // wrong box -> timeout
    run_mole(3'b011, V, 4'b0011);                 // last-cycle hit with extra bit
    run_mole(3'b101, 0, 4'b0000);                 // timeout 2
    run_mole(3'b110, 0, 4'b0000);                 // timeout 3 -> OVER

    over_cyc = mole_at - G;
    goto(over_cyc);
    for (int j = 0; j < 5; j++) begin
      bus.hit_in  = 4'b1111;
      bus.lfsr_in = 3'(j);
      @(negedge clk);
    end
    bus.hit_in = 4'b0000;
    chk("over_game_over", int'(bus.game_over), 1);
    chk("over_frozen_score", int'(bus.score), SMAX);
    chk("over_frozen_misses", int'(bus.misses), MAXM);
    chk("over_mole_valid_low", int'(bus.mole_valid), 0);
    chk("over_mole_onehot", int'(bus.mole_onehot), 0);
    chk("over_box_idx_hold", int'(bus.box_idx), 2);

    start_game();                                 // restart from OVER
    run_mole(3'b100, 1, 4'b0001);

    m = mole_at;                                  // reset while SHOW
    goto(m - 1);
    bus.lfsr_in = 3'b111;
    push_ev(EV_MOLE, m, 3, exp_score, exp_misses);
    goto(m + 2);
    reset = 1'b1;
    goto(m + 3);
    reset = 1'b0;
    chk_all_zero("midshow_reset");
    goto(m + 15);
    chk("idle_no_mole", int'(bus.mole_valid), 0);

    start_game();
    run_mole(3'b010, 0, 4'b0000);
    goto(mole_at - G + 2);
    chk("queue_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    checks++;
    failures++;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
